// File: rtl/tank_tick_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_sched_pkg
// Purpose  : Shared definitions for the tank tick scheduler. Holds the timer
//            register map, the control-register bit positions, the scheduler
//            state encoding and the period-to-load-value helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tick_sched_pkg;

  // Timer slave register map
  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_CONTROL = 4'd1;
  localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
  localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
  localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
  localparam logic [3:0] ADDR_PERIOD3 = 4'd5;
  localparam logic [3:0] ADDR_SNAP0   = 4'd6;
  localparam logic [3:0] ADDR_SNAP1   = 4'd7;
  localparam logic [3:0] ADDR_SNAP2   = 4'd8;
  localparam logic [3:0] ADDR_SNAP3   = 4'd9;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic [15:0] CTRL_RUN_WORD  = (16'd1 << CTRL_START) | (16'd1 << CTRL_CONT)
                                         | (16'd1 << CTRL_ITO);
  localparam logic [15:0] CTRL_STOP_WORD = (16'd1 << CTRL_STOP);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_PROG = 3'd1,
    ST_IDLE = 3'd2,
    ST_RUN  = 3'd3,
    ST_ACK  = 3'd4,
    ST_STOP = 3'd5,
    ST_SNAP = 3'd6
  } state_t;

  // The timer counts load..0, so the load value is period-1. Periods below
  // 2 would give a zero load (a timer that never times out), so clamp to 2.
  function automatic logic [63:0] load_value(input logic [63:0] period);
    return (period < 64'd2) ? 64'd1 : (period - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tank_tick_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : tank_tick_scheduler_if
// Purpose  : 16-bit register-slave bus between the tick scheduler (master)
//            and the 64-bit interval timer (slave), plus the timer IRQ.
// Signals  : address[3:0], chipselect, write_n, writedata[15:0] (master out)
//            readdata[15:0] (registered, one cycle after address), irq (level)
// Revision : 1.0 - initial release
// ============================================================================
interface tank_tick_scheduler_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface
`default_nettype wire

// File: rtl/tank_tick_scheduler_snap_reader.sv
`default_nettype none
// ============================================================================
// Module   : tick_sched_snap_reader
// Purpose  : Snapshot pipeline. On start it writes SNAP0 to latch the timer
//            counter, reads SNAP0..SNAP3 back-to-back and assembles the 64-bit
//            value, pulsing valid_o once complete. Used only when
//            TICK_SCHED_SNAPSHOT_EN is defined.
// Ports    : clk, reset_n (sync, active-low), start_i (accept pulse),
//            rdata_i (timer readdata), bus_cs_o/bus_wn_o/bus_addr_o (bus
//            request, writedata is always 0), last_o (final step),
//            valid_o (one-cycle pulse), value_o (captured counter)
// Revision : 1.0 - initial release
// ============================================================================
module tick_sched_snap_reader
  import tick_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [15:0] rdata_i,
  output logic        bus_cs_o,
  output logic        bus_wn_o,
  output logic [3:0]  bus_addr_o,
  output logic        last_o,
  output logic        valid_o,
  output logic [63:0] value_o
);

  // step 0 idle, 1 latch write, 2..5 reads, 3..6 captures
  logic [2:0]  step_q, step_d;
  logic [63:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic [1:0]  w_cap_idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      step_q  <= 3'd0;
      value_q <= 64'd0;
      valid_q <= 1'b0;
    end else begin
      step_q  <= step_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  // Steps 3..6 capture halfwords 0..3: the low two bits plus one wrap to it.
  assign w_cap_idx = step_q[1:0] + 2'd1;

  always_comb begin
    step_d  = step_q;
    value_d = value_q;
    valid_d = 1'b0;
    if (step_q == 3'd0) begin
      if (start_i) step_d = 3'd1;
    end else if (step_q == 3'd6) begin
      step_d  = 3'd0;
      valid_d = 1'b1;
    end else begin
      step_d = step_q + 3'd1;
    end
    if (step_q >= 3'd3 && step_q <= 3'd6)
      value_d[{w_cap_idx, 4'b0000} +: 16] = rdata_i;
  end

  always_comb begin
    bus_cs_o   = 1'b0;
    bus_wn_o   = 1'b1;
    bus_addr_o = ADDR_STATUS;
    if (step_q == 3'd1) begin
      bus_cs_o   = 1'b1;
      bus_wn_o   = 1'b0;
      bus_addr_o = ADDR_SNAP0;
    end else if (step_q >= 3'd2 && step_q <= 3'd5) begin
      bus_cs_o   = 1'b1;
      bus_addr_o = ADDR_SNAP0 + {1'b0, step_q - 3'd2};
    end
  end

  assign last_o  = (step_q == 3'd6);
  assign valid_o = valid_q;
  assign value_o = value_q;

endmodule
`default_nettype wire

// File: rtl/tank_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tank_tick_scheduler
// Purpose  : Sole master of the interval timer slave. Programs period and
//            control after reset / on request, services the timer IRQ and
//            converts each timeout into a one-cycle tick plus a tick count.
//            Optional snapshot path enabled by macro TICK_SCHED_SNAPSHOT_EN.
// Ports    : clk, reset_n (sync, active-low)
//            cfg_valid_i/cfg_ready_o/cfg_period_i/cfg_run_i : reprogram req
//            tick_o, tick_count_o, running_o               : game outputs
//            snap_req_i/snap_ready_o/snap_valid_o/snap_value_o : snapshot
//            tmr (tank_tick_scheduler_if.master)           : timer bus
// Revision : 1.0 - initial release
// ============================================================================
module tank_tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter logic [63:0] DEFAULT_PERIOD = 64'd50000,
  parameter bit          AUTO_START     = 1'b1
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [63:0] cfg_period_i,
  input  logic        cfg_run_i,
  output logic        tick_o,
  output logic [31:0] tick_count_o,
  output logic        running_o,
  input  logic        snap_req_i,
  output logic        snap_ready_o,
  output logic        snap_valid_o,
  output logic [63:0] snap_value_o,
  tank_tick_scheduler_if.master tmr
);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [63:0] load_q, load_d;
  logic        running_q, running_d;
  logic [31:0] tick_count_q, tick_count_d;

  logic        w_cfg_accept;
  logic        w_snap_accept;
  logic        w_snap_cs;
  logic        w_snap_wn;
  logic [3:0]  w_snap_addr;
  logic        w_snap_last;

  assign cfg_ready_o   = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !tmr.irq);
  assign w_cfg_accept  = cfg_valid_i && cfg_ready_o;
  assign w_snap_accept = snap_req_i && snap_ready_o;

`ifdef TICK_SCHED_SNAPSHOT_EN
  // cfg takes priority over snap, so snap is withheld whenever cfg is offered
  assign snap_ready_o = (state_q == ST_RUN) && !tmr.irq && !cfg_valid_i;

  tick_sched_snap_reader u_snap_reader (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (w_snap_accept),
    .rdata_i    (tmr.readdata),
    .bus_cs_o   (w_snap_cs),
    .bus_wn_o   (w_snap_wn),
    .bus_addr_o (w_snap_addr),
    .last_o     (w_snap_last),
    .valid_o    (snap_valid_o),
    .value_o    (snap_value_o)
  );
`else
  logic w_unused_rdata;

  assign snap_ready_o   = 1'b0;
  assign snap_valid_o   = 1'b0;
  assign snap_value_o   = 64'd0;
  assign w_snap_cs      = 1'b0;
  assign w_snap_wn      = 1'b1;
  assign w_snap_addr    = ADDR_STATUS;
  assign w_snap_last    = 1'b0;
  assign w_unused_rdata = ^tmr.readdata;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      idx_q        <= 3'd0;
      load_q       <= 64'd0;
      running_q    <= 1'b0;
      tick_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      load_q       <= load_d;
      running_q    <= running_d;
      tick_count_q <= tick_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    load_d       = load_q;
    running_d    = running_q;
    tick_count_d = tick_count_q;
    case (state_q)
      ST_INIT: begin
        load_d  = load_value(DEFAULT_PERIOD);
        idx_d   = 3'd0;
        state_d = AUTO_START ? ST_PROG : ST_IDLE;
      end
      ST_PROG: begin
        if (idx_q == 3'd4) begin
          idx_d     = 3'd0;
          running_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_IDLE, ST_RUN: begin
        // IDLE ignores the IRQ: it cannot assert while ITO is cleared
        if ((state_q == ST_RUN) && tmr.irq) begin
          state_d = ST_ACK;
        end else if (w_cfg_accept) begin
          idx_d = 3'd0;
          if (cfg_run_i) begin
            load_d  = load_value(cfg_period_i);
            state_d = ST_PROG;
          end else begin
            state_d = ST_STOP;
          end
        end else if (w_snap_accept) begin
          state_d = ST_SNAP;
        end
      end
      ST_ACK: begin
        tick_count_d = tick_count_q + 32'd1;
        state_d      = ST_RUN;
      end
      ST_STOP: begin
        if (idx_q == 3'd1) begin
          idx_d     = 3'd0;
          running_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_SNAP: begin
        if (w_snap_last) state_d = ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Output logic: bus cycles decoded from the current state and write index
  always_comb begin
    tmr.chipselect = 1'b0;
    tmr.write_n    = 1'b1;
    tmr.address    = ADDR_STATUS;
    tmr.writedata  = 16'd0;
    tick_o         = 1'b0;
    case (state_q)
      ST_PROG: begin
        tmr.chipselect = 1'b1;
        tmr.write_n    = 1'b0;
        if (idx_q == 3'd4) begin
          tmr.address   = ADDR_CONTROL;
          tmr.writedata = CTRL_RUN_WORD;
        end else begin
          tmr.address   = ADDR_PERIOD0 + {2'b00, idx_q[1:0]};
          tmr.writedata = load_q[{idx_q[1:0], 4'b0000} +: 16];
        end
      end
      ST_ACK: begin
        tmr.chipselect = 1'b1;
        tmr.write_n    = 1'b0;
        tick_o         = 1'b1;
      end
      ST_STOP: begin
        tmr.chipselect = 1'b1;
        tmr.write_n    = 1'b0;
        if (idx_q == 3'd0) begin
          tmr.address   = ADDR_CONTROL;
          tmr.writedata = CTRL_STOP_WORD;
        end
      end
      ST_SNAP: begin
        tmr.chipselect = w_snap_cs;
        tmr.write_n    = w_snap_wn;
        tmr.address    = w_snap_addr;
      end
      default: ;
    endcase
  end

  assign tick_count_o = tick_count_q;
  assign running_o    = running_q;

endmodule
`default_nettype wire

// File: tb/tb_tank_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_tick_scheduler
// Purpose  : Self-checking bench for tank_tick_scheduler with a small timer
//            slave model (registered readdata, snapshot latch on SNAP0 write).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tank_tick_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_valid, cfg_ready, cfg_run;
  logic [63:0] cfg_period;
  logic        tick, running;
  logic [31:0] tick_count;
  logic        snap_req, snap_ready, snap_valid;
  logic [63:0] snap_value;

  int n_chk  = 0;
  int n_fail = 0;

  tank_tick_scheduler_if tmr_if ();

  tank_tick_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_period_i (cfg_period),
    .cfg_run_i    (cfg_run),
    .tick_o       (tick),
    .tick_count_o (tick_count),
    .running_o    (running),
    .snap_req_i   (snap_req),
    .snap_ready_o (snap_ready),
    .snap_valid_o (snap_valid),
    .snap_value_o (snap_value),
    .tmr          (tmr_if)
  );

  always #5 clk = ~clk;

  // Timer slave model: counter value latched by a write to SNAP0
  logic [63:0] tmr_counter;
  logic [63:0] tmr_snap;
  always @(posedge clk) begin
    if (!reset_n) begin
      tmr_if.readdata <= 16'd0;
      tmr_snap        <= 64'd0;
    end else begin
      tmr_if.readdata <= 16'd0;
      if (tmr_if.chipselect && !tmr_if.write_n && tmr_if.address == 4'd6)
        tmr_snap <= tmr_counter;
      if (tmr_if.chipselect && tmr_if.write_n) begin
        case (tmr_if.address)
          4'd6: tmr_if.readdata <= tmr_snap[15:0];
          4'd7: tmr_if.readdata <= tmr_snap[31:16];
          4'd8: tmr_if.readdata <= tmr_snap[47:32];
          4'd9: tmr_if.readdata <= tmr_snap[63:48];
          default: tmr_if.readdata <= 16'd0;
        endcase
      end
    end
  end

  typedef struct {
    logic        irq;
    logic        cs;
    logic        wn;
    logic [3:0]  addr;
    logic [15:0] wd;
    logic        tick;
    logic        run;
    logic        crdy;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mkv(logic irq, logic cs, logic wn, logic [3:0] addr,
                               logic [15:0] wd, logic tk, logic run, logic crdy,
                               logic [31:0] cnt);
    vec_t v;
    v.irq = irq; v.cs = cs; v.wn = wn; v.addr = addr; v.wd = wd;
    v.tick = tk; v.run = run; v.crdy = crdy; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Bus fields packed as {cs, wn, addr, wdata}
  task automatic expect_bus(input string nm, input logic cs, input logic wn,
                            input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    chk(nm, {42'd0, tmr_if.chipselect, tmr_if.write_n, tmr_if.address, tmr_if.writedata},
            {42'd0, cs, wn, a, d});
    next();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    cfg_valid  = 1'b0;
    cfg_run    = 1'b0;
    cfg_period = 64'd0;
    snap_req   = 1'b0;
    tmr_if.irq = 1'b0;
    tmr_counter = 64'h0000_0001_0000_2345;

    // {irq, cs, wn, addr, wdata, tick, running, cfg_ready, tick_count}
    vecs[0]  = mkv(0, 0, 1, 4'd0, 16'h0000, 0, 0, 0, 0);  // INIT
    vecs[1]  = mkv(0, 1, 0, 4'd2, 16'hC34F, 0, 0, 0, 0);  // 50000-1
    vecs[2]  = mkv(0, 1, 0, 4'd3, 16'h0000, 0, 0, 0, 0);
    vecs[3]  = mkv(0, 1, 0, 4'd4, 16'h0000, 0, 0, 0, 0);
    vecs[4]  = mkv(0, 1, 0, 4'd5, 16'h0000, 0, 0, 0, 0);
    vecs[5]  = mkv(0, 1, 0, 4'd1, 16'h0007, 0, 0, 0, 0);
    vecs[6]  = mkv(0, 0, 1, 4'd0, 16'h0000, 0, 1, 1, 0);  // RUN
    vecs[7]  = mkv(1, 0, 1, 4'd0, 16'h0000, 0, 1, 0, 0);  // IRQ sampled
    vecs[8]  = mkv(0, 1, 0, 4'd0, 16'h0000, 1, 1, 0, 0);  // ACK + tick
    vecs[9]  = mkv(0, 0, 1, 4'd0, 16'h0000, 0, 1, 1, 1);
    vecs[10] = mkv(0, 0, 1, 4'd0, 16'h0000, 0, 1, 1, 1);

    repeat (3) next();
    @(negedge clk);
    chk("rst_outputs", {58'd0, tick, running, cfg_ready, snap_ready, snap_valid, 1'b0},
                       64'd0);
    chk("rst_count", {32'd0, tick_count}, 64'd0);
    chk("rst_snap_value", snap_value, 64'd0);
    chk("rst_bus", {42'd0, tmr_if.chipselect, tmr_if.write_n, tmr_if.address, tmr_if.writedata},
                   {42'd0, 1'b0, 1'b1, 4'd0, 16'd0});
    next();
    reset_n = 1'b1;   // cycle 0 starts here

    for (int i = 0; i < 11; i++) begin
      tmr_if.irq = vecs[i].irq;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {7'd0, tmr_if.chipselect, tmr_if.write_n, tmr_if.address, tmr_if.writedata,
           tick, running, cfg_ready, tick_count},
          {7'd0, vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd,
           vecs[i].tick, vecs[i].run, vecs[i].crdy, vecs[i].cnt});
      next();
    end

    // Period 1 clamps to load value 1
    cfg_valid = 1'b1; cfg_run = 1'b1; cfg_period = 64'd1;
    @(negedge clk);
    chk("p1_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    next();
    cfg_valid = 1'b0;
    expect_bus("p1_w2", 1, 0, 4'd2, 16'h0001);
    expect_bus("p1_w3", 1, 0, 4'd3, 16'h0000);
    expect_bus("p1_w4", 1, 0, 4'd4, 16'h0000);
    expect_bus("p1_w5", 1, 0, 4'd5, 16'h0000);
    expect_bus("p1_w1", 1, 0, 4'd1, 16'h0007);
    @(negedge clk);
    chk("p1_run", {62'd0, running, cfg_ready}, 64'd3);
    next();

    // IRQ rising during PROG is held off until RUN, then serviced once
    cfg_valid = 1'b1; cfg_run = 1'b1; cfg_period = 64'd100;
    next();
    cfg_valid = 1'b0;
    tmr_if.irq = 1'b1;
    expect_bus("pi_w2", 1, 0, 4'd2, 16'h0063);
    expect_bus("pi_w3", 1, 0, 4'd3, 16'h0000);
    expect_bus("pi_w4", 1, 0, 4'd4, 16'h0000);
    expect_bus("pi_w5", 1, 0, 4'd5, 16'h0000);
    expect_bus("pi_w1", 1, 0, 4'd1, 16'h0007);
    @(negedge clk);
    chk("pi_run_wait", {60'd0, tmr_if.chipselect, tick, cfg_ready, running}, 64'd1);
    next();
    @(negedge clk);
    chk("pi_ack", {41'd0, tick, tmr_if.chipselect, tmr_if.write_n, tmr_if.address,
                   tmr_if.writedata}, {41'd0, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0});
    next();
    tmr_if.irq = 1'b0;
    @(negedge clk);
    chk("pi_count", {31'd0, tick, tick_count}, {31'd0, 1'b0, 32'd2});
    next();
    @(negedge clk);
    chk("pi_no_double", {31'd0, tick, tick_count}, {31'd0, 1'b0, 32'd2});
    next();

    // Stop request
    cfg_valid = 1'b1; cfg_run = 1'b0;
    next();
    cfg_valid = 1'b0;
    expect_bus("stop_ctrl", 1, 0, 4'd1, 16'h0008);
    expect_bus("stop_status", 1, 0, 4'd0, 16'h0000);
    @(negedge clk);
    chk("stop_idle", {29'd0, tmr_if.chipselect, running, cfg_ready, tick_count},
                     {29'd0, 1'b0, 1'b0, 1'b1, 32'd2});
    next();
    tmr_if.irq = 1'b1;
    @(negedge clk);
    chk("idle_irq_ignored", {61'd0, tmr_if.chipselect, tick, cfg_ready}, 64'd1);
    next();
    tmr_if.irq = 1'b0;
    @(negedge clk);
    chk("idle_hold", {29'd0, tmr_if.chipselect, tick, running, tick_count},
                     {29'd0, 3'b000, 32'd2});
    next();

    // Restart from IDLE
    cfg_valid = 1'b1; cfg_run = 1'b1; cfg_period = 64'd50000;
    next();
    cfg_valid = 1'b0;
    repeat (5) next();
    @(negedge clk);
    chk("restart_run", {63'd0, running}, 64'd1);
    next();

`ifdef TICK_SCHED_SNAPSHOT_EN
    snap_req = 1'b1;
    @(negedge clk);
    chk("snap_ready", {63'd0, snap_ready}, 64'd1);
    next();
    snap_req = 1'b0;
    expect_bus("snap_latch", 1, 0, 4'd6, 16'h0000);
    expect_bus("snap_rd6", 1, 1, 4'd6, 16'h0000);
    expect_bus("snap_rd7", 1, 1, 4'd7, 16'h0000);
    expect_bus("snap_rd8", 1, 1, 4'd8, 16'h0000);
    expect_bus("snap_rd9", 1, 1, 4'd9, 16'h0000);
    @(negedge clk);
    chk("snap_a6", {62'd0, tmr_if.chipselect, snap_valid}, 64'd0);
    next();
    @(negedge clk);
    chk("snap_valid", {63'd0, snap_valid}, 64'd1);
    chk("snap_value", snap_value, 64'h0000_0001_0000_2345);
    next();
    @(negedge clk);
    chk("snap_done", {62'd0, snap_valid, cfg_ready}, 64'd1);
    next();
`else
    begin
      logic seen;
      seen = 1'b0;
      snap_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        seen = seen | snap_valid | snap_ready | tmr_if.chipselect;
        next();
      end
      snap_req = 1'b0;
      chk("nosnap_quiet", {63'd0, seen}, 64'd0);
      chk("nosnap_value", snap_value, 64'd0);
    end
`endif

    // Reset mid-PROG abandons the sequence; INIT reruns with defaults
    cfg_valid = 1'b1; cfg_run = 1'b1; cfg_period = 64'd1000;
    next();
    cfg_valid = 1'b0;
    expect_bus("mid_w2", 1, 0, 4'd2, 16'h03E7);
    reset_n = 1'b0;
    next();
    @(negedge clk);
    chk("mid_rst", {29'd0, tmr_if.chipselect, running, tick, tick_count}, 64'd0);
    next();
    reset_n = 1'b1;
    expect_bus("mid_init", 0, 1, 4'd0, 16'h0000);
    expect_bus("mid_w2_default", 1, 0, 4'd2, 16'hC34F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tank_tick_scheduler.md
# tank_tick_scheduler

Sequencer and owner of the 64-bit interval timer's 16-bit register slave. It programs the timer period and control word after reset and on request, services the timer IRQ, and turns each timeout into a one-cycle game `tick` plus a running tick count. It is the sole master on the timer slave and sits between game-control logic and the timer.

## Interface
- `DEFAULT_PERIOD`, 64'd50000: tick interval in clk cycles, programmed after reset.
- `AUTO_START`, 1: when 1, the timer is started after reset; when 0, the block parks in IDLE.
- `clk`  in  1: system clock; only clock.
- `reset_n`  in  1: reset, synchronous, active-low.
- `cfg_valid`  in  1: reprogram request.
- `cfg_ready`  out  1: request accepted when `cfg_valid && cfg_ready`.
- `cfg_period`  in  64: new interval in cycles.
- `cfg_run`  in  1: 1 = program and start; 0 = stop.
- `tick`  out  1: one-cycle pulse per serviced timeout.
- `tick_count`  out  32: serviced timeouts since reset; wraps.
- `running`  out  1: timer started by this block.
- `snap_req`  in  1: snapshot request, accepted only when `snap_ready`.
- `snap_ready`  out  1: snapshot can be accepted.
- `snap_valid`  out  1: one-cycle pulse, `snap_value` valid.
- `snap_value`  out  64: captured counter value.
- `tmr_address`  out  4, `tmr_chipselect`  out  1, `tmr_write_n`  out  1, `tmr_writedata`  out  16: timer slave bus.
- `tmr_readdata`  in  16: registered slave read data, one cycle after the address.
- `tmr_irq`  in  1: level IRQ from the timer.

## Operation
- Bus cycles: writes are single-cycle with no wait state. Reads: drive the address in cycle k, sample `tmr_readdata` in k+1. When the bus is idle: `chipselect`=0, `write_n`=1, `address`=0, `writedata`=0.
- States: INIT, PROG, IDLE, RUN, ACK, STOP, SNAP.
- INIT runs for one cycle after reset. It loads `DEFAULT_PERIOD` and goes to PROG if `AUTO_START`, otherwise to IDLE.
- PROG performs 5 back-to-back writes:
  - addresses 2, 3, 4, 5 take halfwords 0..3 of (period−1);
  - address 1 takes 4'b0111 (START | CONT | ITO).
  - It then sets `running` and goes to RUN.
- Period arithmetic: the load value is period−1 in 64 bits. Periods 0 and 1 are clamped to 2, giving load value 1.
- RUN priority: `tmr_irq` → ACK, then accepted cfg, then accepted snap.
- ACK: one write of 0 to address 0. `tick` is high in this cycle and `tick_count` increments at its end. Returns to RUN.
- The timer's IRQ is already low in the following cycle, so no double tick occurs.
- An IRQ arriving during PROG or SNAP stays pending at level and is serviced on return to RUN. It is delayed, never dropped.
- Accepted cfg with `cfg_run`=1 → PROG with `cfg_period`.
- Accepted cfg with `cfg_run`=0 → STOP:
  - write address 1 with 4'b1000;
  - then write address 0 with 0, clearing any pending timeout;
  - clear `running` and go to IDLE. `tick_count` holds.
- IDLE accepts cfg only. It ignores `tmr_irq`, because the IRQ cannot assert with ITO cleared.
- `cfg_ready` is high only in IDLE, and in RUN when `tmr_irq`=0.
- `snap_ready` is high only in RUN when `tmr_irq`=0 and `cfg_valid`=0.
- Reset values: `tick`=0, `tick_count`=0, `running`=0, `cfg_ready`=0, `snap_ready`=0, `snap_valid`=0, `snap_value`=0, bus idle.
- Reset asserted mid-sequence abandons the sequence. INIT reruns after release.

## Timing
- Post-reset start: reset released at cycle 0 → INIT at 0, PROG writes at 1..5, RUN at 6.
- Reprogram latency: accepted at cycle a → PROG writes at a+1..a+5, RUN at a+6.
- IRQ service: `tmr_irq` sampled high in RUN at cycle c → ACK write and `tick` at c+1.
- Stop: accepted at a → writes at a+1 and a+2, IDLE at a+3.
- Snapshot: accepted at a →
  - write address 6 at a+1;
  - addresses 6, 7, 8, 9 at a+2..a+5;
  - data captured at a+3..a+6;
  - `snap_valid` at a+7, RUN at a+7.

## Configuration
- `TICK_SCHED_SNAPSHOT_EN` defined: the SNAP state and snapshot read path are present, as specified above.
- Not defined: SNAP is removed. `snap_ready`, `snap_valid` and `snap_value` are tied to 0, and `snap_req` is ignored. All other timing is unchanged.

## Structure
- Package `tick_sched_pkg` holds:
  - timer register address constants (STATUS=0, CONTROL=1, PERIOD0..3=2..5, SNAP0..3=6..9);
  - control bit positions (ITO=0, CONT=1, START=2, STOP=3);
  - the state enum.
- Sub-module `tick_sched_snap_reader` holds the address/capture pipeline. It is instantiated only under `TICK_SCHED_SNAPSHOT_EN`.
- Everything else is a single FSM with a 3-bit write index.

## Test plan
- Reset with defaults → writes 0xC34F, 0, 0, 0 to addresses 2..5, then 0x7 to address 1 at cycles 1..5; `running`=1 at cycle 6.
- `cfg_period`=1 with `cfg_run`=1 → load value 1 written (0x0001 to address 2, then 0 to addresses 3..5), not 0.
- `tmr_irq` held high for 1 cycle in RUN → exactly one write of 0 to address 0, one `tick` pulse, `tick_count` 0→1.
- `tmr_irq` rising during PROG → ACK issued in the cycle after RUN is re-entered; `tick_count` increments once.
- Stop request → 0x8 to address 1, then 0 to address 0; IDLE; `running`=0.
- With the macro, timer model counter at 0x0000_0001_0000_2345 → `snap_value` equals it, `snap_valid` at a+7; without the macro, `snap_valid` never asserts.
